// File: rtl/sc_metric_calc_pkg.sv
// Shared constants, types and rounding helpers for the Schmidl-Cox metric block.
// Build option: SC_METRIC_ROUND_EN selects round-half-up (else floor) on the >>15.
package sc_metric_calc_pkg;

  localparam int SC_LAG    = 64;
  localparam int SC_WIN    = 64;
  localparam int SC_FILL   = SC_LAG + SC_WIN;
  localparam int SC_IN_W   = 16;
  localparam int SC_PROD_W = 18;
  localparam int SC_E_W    = 17;
  localparam int SC_ACC_W  = 23;

  typedef struct packed {
    logic signed [SC_IN_W-1:0] re;
    logic signed [SC_IN_W-1:0] im;
  } sc_cplx_t;

  typedef struct packed {
    logic signed [SC_PROD_W-1:0] re;
    logic signed [SC_PROD_W-1:0] im;
  } sc_prod_t;

  // Q2.30 sum of two products -> 18-bit signed, LSB 2^-15.
  function automatic logic signed [SC_PROD_W-1:0] sc_shr15(
    input logic signed [32:0] v
  );
    logic signed [32:0] t;
`ifdef SC_METRIC_ROUND_EN
    t = v + 33'sd16384;
`else
    t = v;
`endif
    return SC_PROD_W'(t >>> 15);
  endfunction

  // Non-negative energy -> 17-bit unsigned, LSB 2^-15.
  function automatic logic [SC_E_W-1:0] sc_eshr15(
    input logic [32:0] v
  );
    logic [32:0] t;
`ifdef SC_METRIC_ROUND_EN
    t = (v + 33'd16384) >> 15;
    if (t > 33'h1FFFF) t = 33'h1FFFF;
`else
    t = v >> 15;
`endif
    return SC_E_W'(t);
  endfunction

endpackage

// File: rtl/sc_delay_line.sv
// Circular-buffer delay line: dout_o is the word written DEPTH enables ago.
// Ports: clk, clr_i (sync clear of contents+pointer), en_i (advance), din_i, dout_o.
module sc_delay_line
  import sc_metric_calc_pkg::*;
#(
  parameter int WIDTH = SC_IN_W,
  parameter int DEPTH = SC_LAG
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;

  // Oldest entry sits at the write pointer; it is read before being overwritten.
  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[ptr_q] <= din_i;
      ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sc_metric_calc.sv
// Schmidl-Cox metrics: |P| of the LAG-delayed autocorrelation and window energy R.
// In: clk, rst (sync), cyc_i (low flushes), ena, in_vld, in_re/in_im (Q1.15).
// Out: P_Metric_mag, R_Metric (23b, LSB 2^-15), metric_vld. Option: SC_METRIC_ROUND_EN.
module sc_metric_calc
  import sc_metric_calc_pkg::*;
#(
  parameter int LAG = SC_LAG,
  parameter int WIN = SC_WIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc_i,
  input  logic                ena,
  input  logic                in_vld,
  input  logic [SC_IN_W-1:0]  in_re,
  input  logic [SC_IN_W-1:0]  in_im,
  output logic [SC_ACC_W-1:0] P_Metric_mag,
  output logic [SC_ACC_W-1:0] R_Metric,
  output logic                metric_vld
);

  localparam int FILL = LAG + WIN;
  localparam int CW   = $clog2(FILL + 1);

  logic clr;
  logic acc;
  assign clr = rst | ~cyc_i;
  assign acc = cyc_i & ena & in_vld;

  sc_cplx_t x_in;
  sc_cplx_t x_del;
  assign x_in = {in_re, in_im};

  logic [CW-1:0] cnt_q, cnt_d;

  // Stage 1
  sc_cplx_t x1_q, xd1_q;
  logic     v1_q, f1_q;
  // Stage 2
  sc_prod_t          c2_q;
  logic [SC_E_W-1:0] e2_q;
  logic              v2_q, f2_q;
  // Stage 3
  logic signed [SC_ACC_W-1:0] pre_q, pre_d;
  logic signed [SC_ACC_W-1:0] pim_q, pim_d;
  logic [SC_ACC_W-1:0]        r_q, r_d;
  logic                       v3_q, f3_q;
  // Stage 4
  logic [SC_ACC_W-1:0] mx4_q, mn4_q, r4_q;
  logic [SC_ACC_W-1:0] mx_d, mn_d;
  logic                v4_q, f4_q;
  logic [SC_ACC_W-1:0] mag_d;

  sc_prod_t          c_del;
  logic [SC_E_W-1:0] e_del;

  sc_delay_line #(.WIDTH($bits(sc_cplx_t)), .DEPTH(LAG)) u_xdl (
    .clk    (clk),
    .clr_i  (clr),
    .en_i   (acc),
    .din_i  (x_in),
    .dout_o (x_del)
  );

  sc_delay_line #(.WIDTH($bits(sc_prod_t)), .DEPTH(WIN)) u_cdl (
    .clk    (clk),
    .clr_i  (clr),
    .en_i   (v2_q),
    .din_i  (c2_q),
    .dout_o (c_del)
  );

  sc_delay_line #(.WIDTH(SC_E_W), .DEPTH(WIN)) u_edl (
    .clk    (clk),
    .clr_i  (clr),
    .en_i   (v2_q),
    .din_i  (e2_q),
    .dout_o (e_del)
  );

  function automatic logic signed [SC_ACC_W-1:0] sx(
    input logic signed [SC_PROD_W-1:0] v
  );
    return {{(SC_ACC_W-SC_PROD_W){v[SC_PROD_W-1]}}, v};
  endfunction

  function automatic logic [SC_ACC_W-1:0] abs23(
    input logic signed [SC_ACC_W-1:0] v
  );
    return v[SC_ACC_W-1] ? SC_ACC_W'(-v) : SC_ACC_W'(v);
  endfunction

  // x1 * conj(xd1): re = ac + bd, im = bc - ad
  logic signed [31:0] p_ac, p_bd, p_bc, p_ad, p_aa, p_bb;
  logic signed [32:0] c_re_s, c_im_s;
  logic [32:0]        e_s;

  assign p_ac   = $signed(x1_q.re) * $signed(xd1_q.re);
  assign p_bd   = $signed(x1_q.im) * $signed(xd1_q.im);
  assign p_bc   = $signed(x1_q.im) * $signed(xd1_q.re);
  assign p_ad   = $signed(x1_q.re) * $signed(xd1_q.im);
  assign p_aa   = $signed(x1_q.re) * $signed(x1_q.re);
  assign p_bb   = $signed(x1_q.im) * $signed(x1_q.im);
  assign c_re_s = {p_ac[31], p_ac} + {p_bd[31], p_bd};
  assign c_im_s = {p_bc[31], p_bc} - {p_ad[31], p_ad};
  assign e_s    = {1'b0, p_aa} + {1'b0, p_bb};

  logic [SC_ACC_W-1:0] a_re, a_im;
  logic [SC_ACC_W:0]   mag_sum;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && cnt_q != CW'(FILL)) cnt_d = cnt_q + 1'b1;
    pre_d = pre_q + sx(c2_q.re) - sx(c_del.re);
    pim_d = pim_q + sx(c2_q.im) - sx(c_del.im);
    r_d   = r_q + SC_ACC_W'(e2_q) - SC_ACC_W'(e_del);
    a_re  = abs23(pre_q);
    a_im  = abs23(pim_q);
    mx_d  = (a_re >= a_im) ? a_re : a_im;
    mn_d  = (a_re >= a_im) ? a_im : a_re;
    mag_sum = {1'b0, mx4_q} + {2'b0, mn4_q[SC_ACC_W-1:1]};
    mag_d = mag_sum[SC_ACC_W] ? '1 : mag_sum[SC_ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q        <= '0;
      x1_q         <= '0;
      xd1_q        <= '0;
      v1_q         <= 1'b0;
      f1_q         <= 1'b0;
      c2_q         <= '0;
      e2_q         <= '0;
      v2_q         <= 1'b0;
      f2_q         <= 1'b0;
      pre_q        <= '0;
      pim_q        <= '0;
      r_q          <= '0;
      v3_q         <= 1'b0;
      f3_q         <= 1'b0;
      mx4_q        <= '0;
      mn4_q        <= '0;
      r4_q         <= '0;
      v4_q         <= 1'b0;
      f4_q         <= 1'b0;
      P_Metric_mag <= '0;
      R_Metric     <= '0;
      metric_vld   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      v1_q  <= acc;
      if (acc) begin
        x1_q  <= x_in;
        xd1_q <= x_del;
        f1_q  <= (cnt_q == CW'(FILL));
      end
      v2_q <= v1_q;
      if (v1_q) begin
        c2_q.re <= sc_shr15(c_re_s);
        c2_q.im <= sc_shr15(c_im_s);
        e2_q    <= sc_eshr15(e_s);
        f2_q    <= f1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        pre_q <= pre_d;
        pim_q <= pim_d;
        r_q   <= r_d;
        f3_q  <= f2_q;
      end
      v4_q <= v3_q;
      if (v3_q) begin
        mx4_q <= mx_d;
        mn4_q <= mn_d;
        r4_q  <= r_q;
        f4_q  <= f3_q;
      end
      metric_vld <= v4_q & f4_q;
      if (v4_q) begin
        P_Metric_mag <= mag_d;
        R_Metric     <= r4_q;
      end
    end
  end

endmodule

// File: tb/tb_sc_metric_calc.sv
// Randomised bench for sc_metric_calc against a sample-indexed reference model.
// The model keeps the frame history and recomputes P/R as explicit window sums.
module tb_sc_metric_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_i = 1'b0;
  logic        ena = 1'b0;
  logic        in_vld = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic [22:0] P_Metric_mag;
  logic [22:0] R_Metric;
  logic        metric_vld;

  always #5 clk = ~clk;

  sc_metric_calc dut (
    .clk          (clk),
    .rst          (rst),
    .cyc_i        (cyc_i),
    .ena          (ena),
    .in_vld       (in_vld),
    .in_re        (in_re),
    .in_im        (in_im),
    .P_Metric_mag (P_Metric_mag),
    .R_Metric     (R_Metric),
    .metric_vld   (metric_vld)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int fill_acc_cyc = -1;

  typedef struct {
    int          due;
    logic [22:0] mag;
    logic [22:0] r;
    bit          fill;
  } exp_t;

  exp_t   pend[$];
  longint hx_re[$];
  longint hx_im[$];
  longint hc_re[$];
  longint hc_im[$];
  longint he[$];

  logic [22:0] exp_mag = '0;
  logic [22:0] exp_r = '0;
  logic        exp_vld = 1'b0;

  function automatic longint sh(input longint v);
`ifdef SC_METRIC_ROUND_EN
    return (v + 16384) >>> 15;
`else
    return v >>> 15;
`endif
  endfunction

  function automatic longint she(input longint v);
    longint t;
    t = sh(v);
`ifdef SC_METRIC_ROUND_EN
    if (t > 131071) t = 131071;
`endif
    return t;
  endfunction

  function automatic void model_clear();
    pend.delete();
    hx_re.delete();
    hx_im.delete();
    hc_re.delete();
    hc_im.delete();
    he.delete();
  endfunction

  function automatic void model_accept(input longint a, input longint b);
    int n;
    longint cr, ci, pr, pi, rr, ar, ai, mx, mn, m;
    logic signed [22:0] pr23, pi23;
    logic [22:0] m23, r23;
    exp_t x;
    n = hx_re.size();
    cr = 0;
    ci = 0;
    if (n >= 64) begin
      cr = hx_re[n-64];
      ci = hx_im[n-64];
    end
    hx_re.push_back(a);
    hx_im.push_back(b);
    hc_re.push_back(sh(a * cr + b * ci));
    hc_im.push_back(sh(b * cr - a * ci));
    he.push_back(she(a * a + b * b));
    pr = 0;
    pi = 0;
    rr = 0;
    for (int k = n; k >= 0 && k > n - 64; k--) begin
      pr += hc_re[k];
      pi += hc_im[k];
      rr += he[k];
    end
    pr23 = pr[22:0];
    pi23 = pi[22:0];
    ar = (pr23 < 0) ? -longint'(pr23) : longint'(pr23);
    ai = (pi23 < 0) ? -longint'(pi23) : longint'(pi23);
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    m = mx + mn / 2;
    if (m > 8388607) m = 8388607;
    m23 = m[22:0];
    r23 = rr[22:0];
    x.due = cyc_n + 4;
    x.mag = m23;
    x.r = r23;
    x.fill = (n >= 128);
    pend.push_back(x);
    if (n == 128) fill_acc_cyc = cyc_n;
  endfunction

  task automatic step(input bit c, input bit e, input bit v,
                      input logic [15:0] re, input logic [15:0] im);
    exp_t e0;
    cyc_i = c;
    ena = e;
    in_vld = v;
    in_re = re;
    in_im = im;
    @(posedge clk);
    cyc_n++;
    exp_vld = 1'b0;
    if (rst || !c) begin
      model_clear();
      exp_mag = '0;
      exp_r = '0;
    end else begin
      while (pend.size() > 0 && pend[0].due == cyc_n) begin
        e0 = pend.pop_front();
        exp_mag = e0.mag;
        exp_r = e0.r;
        exp_vld = e0.fill;
      end
      if (e && v) model_accept(longint'($signed(re)), longint'($signed(im)));
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 1, 16'h4000, 16'h4000);
    if (P_Metric_mag !== 23'd0 || R_Metric !== 23'd0 || metric_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset got mag=%h r=%h vld=%b want 0 0 0",
               P_Metric_mag, R_Metric, metric_vld);
    end
    checks++;
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic run_const(input string nm, input logic [15:0] re,
                           input logic [15:0] im, input int cnt,
                           input logic [22:0] want);
    int first;
    first = -1;
    step(0, 0, 0, 0, 0);
    fill_acc_cyc = -1;
    for (int i = 0; i < cnt + 5; i++) begin
      if (i < cnt) step(1, 1, 1, re, im);
      else step(1, 1, 0, 0, 0);
      if (metric_vld && first < 0) first = cyc_n;
      if (metric_vld !== exp_vld || P_Metric_mag !== exp_mag || R_Metric !== exp_r) begin
        errors++;
        $display("FAIL %s cyc=%0d got vld=%b mag=%h r=%h want vld=%b mag=%h r=%h",
                 nm, cyc_n, metric_vld, P_Metric_mag, R_Metric, exp_vld, exp_mag, exp_r);
      end
      checks++;
    end
    if (cnt > 128) begin
      if (first - fill_acc_cyc !== 4) begin
        errors++;
        $display("FAIL %s_latency got %0d want 4", nm, first - fill_acc_cyc);
      end
      checks++;
    end
    if (P_Metric_mag !== want || R_Metric !== want) begin
      errors++;
      $display("FAIL %s_final got mag=%h r=%h want %h", nm, P_Metric_mag, R_Metric, want);
    end
    checks++;
  endtask

  task automatic test_const_half();
    run_const("const_half", 16'h4000, 16'h0000, 200, 23'h080000);
  endtask

  task automatic test_const_diag();
    run_const("const_diag", 16'h4000, 16'h4000, 200, 23'h100000);
  endtask

  task automatic test_zero();
    run_const("zero", 16'h0000, 16'h0000, 150, 23'h000000);
  endtask

  task automatic test_tiny();
    run_const("tiny", 16'h0001, 16'h0000, 150, 23'h000000);
  endtask

  task automatic test_alternating();
    logic [15:0] re, im;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 384 + 5; i++) begin
      re = ((i / 64) % 2 == 0) ? 16'h4000 : 16'h0000;
      im = ((i / 64) % 2 == 0) ? 16'h0000 : 16'h4000;
      if (i < 384) step(1, 1, 1, re, im);
      else step(1, 1, 0, 0, 0);
      if (metric_vld !== exp_vld || P_Metric_mag !== exp_mag || R_Metric !== exp_r) begin
        errors++;
        $display("FAIL alternating cyc=%0d got vld=%b mag=%h r=%h want vld=%b mag=%h r=%h",
                 cyc_n, metric_vld, P_Metric_mag, R_Metric, exp_vld, exp_mag, exp_r);
      end
      checks++;
    end
    if (P_Metric_mag !== 23'h080000 || R_Metric !== 23'h080000) begin
      errors++;
      $display("FAIL alternating_final got mag=%h r=%h want 080000",
               P_Metric_mag, R_Metric);
    end
    checks++;
  endtask

  task automatic test_gap();
    logic [22:0] hm, hr;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 224; i++) begin
      if (i >= 150 && i < 160)
        step(1, 1'($urandom_range(0, 1)), 0, 16'($urandom), 16'($urandom));
      else
        step(1, 1, 1, 16'($urandom), 16'($urandom));
      if (i == 153) begin
        hm = P_Metric_mag;
        hr = R_Metric;
      end
      if (i > 153 && i < 160) begin
        if (metric_vld !== 1'b0 || P_Metric_mag !== hm || R_Metric !== hr) begin
          errors++;
          $display("FAIL gap_hold cyc=%0d got vld=%b mag=%h r=%h want vld=0 mag=%h r=%h",
                   cyc_n, metric_vld, P_Metric_mag, R_Metric, hm, hr);
        end
        checks++;
      end
      if (metric_vld !== exp_vld || P_Metric_mag !== exp_mag || R_Metric !== exp_r) begin
        errors++;
        $display("FAIL gap cyc=%0d got vld=%b mag=%h r=%h want vld=%b mag=%h r=%h",
                 cyc_n, metric_vld, P_Metric_mag, R_Metric, exp_vld, exp_mag, exp_r);
      end
      checks++;
    end
  endtask

  task automatic test_flush();
    int strobes;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) step(1, 1, 1, 16'($urandom), 16'($urandom));
    step(0, 1, 1, 16'h4000, 16'h4000);
    if (P_Metric_mag !== 23'd0 || R_Metric !== 23'd0 || metric_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got mag=%h r=%h vld=%b want 0 0 0",
               P_Metric_mag, R_Metric, metric_vld);
    end
    checks++;
    strobes = 0;
    for (int i = 0; i < 140; i++) begin
      step(1, 1, 1, 16'($urandom), 16'($urandom));
      if (i < 132 && metric_vld) strobes++;
      if (metric_vld !== exp_vld || P_Metric_mag !== exp_mag || R_Metric !== exp_r) begin
        errors++;
        $display("FAIL flush cyc=%0d got vld=%b mag=%h r=%h want vld=%b mag=%h r=%h",
                 cyc_n, metric_vld, P_Metric_mag, R_Metric, exp_vld, exp_mag, exp_r);
      end
      checks++;
    end
    if (strobes !== 0) begin
      errors++;
      $display("FAIL flush_refill got %0d early strobes want 0", strobes);
    end
    checks++;
  endtask

  task automatic test_random();
    bit c;
    logic [15:0] re, im;
    for (int i = 0; i < 2000; i++) begin
      c = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        re = 16'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF);
        im = 16'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF);
      end else begin
        re = 16'($urandom);
        im = 16'($urandom);
      end
      step(c, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), re, im);
      if (metric_vld !== exp_vld || P_Metric_mag !== exp_mag || R_Metric !== exp_r) begin
        errors++;
        $display("FAIL random cyc=%0d got vld=%b mag=%h r=%h want vld=%b mag=%h r=%h",
                 cyc_n, metric_vld, P_Metric_mag, R_Metric, exp_vld, exp_mag, exp_r);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_const_half();
    test_const_diag();
    test_alternating();
    test_gap();
    test_flush();
    test_zero();
    test_tiny();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_metric_calc.md
# sc_metric_calc

Computes the Schmidl-Cox timing metrics for the 802.16 short preamble. Produces the 64-lag delayed autocorrelation magnitude |P| and the windowed energy R from the incoming complex baseband stream. Sits directly upstream of the coarse time synchroniser, which consumes `P_Metric_mag`, `R_Metric` and the per-sample strobe.

## Interface
- `LAG`, 64: correlation lag in samples. Power of two.
- `WIN`, 64: moving-sum window length in samples. Power of two.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `cyc_i`  in  1  frame/bus cycle active; low flushes all state
- `ena`  in  1  block enable; gates sample acceptance
- `in_vld`  in  1  sample strobe
- `in_re`, `in_im`  in  16 each  signed Q1.15 sample
- `P_Metric_mag`  out  23  unsigned |P|, LSB weight 2^-15
- `R_Metric`  out  23  unsigned R, LSB weight 2^-15
- `metric_vld`  out  1  one-cycle strobe, metrics valid

## Operation
- A sample is accepted on any edge with `cyc_i & ena & in_vld`. Only accepted samples advance the delay lines and accumulators.
- Stage 1 registers x[n]. It reads x[n-LAG] from a delay line.
- Stage 2 computes c[n] = x[n]·conj(x[n-LAG]) and e[n] = |x[n]|².
  - Full products are Q2.30.
  - Results are arithmetic-shifted right by 15: c is 18-bit signed per component, e is 17-bit unsigned.
- Stage 3 updates running sums: P += c[n] − c[n-WIN] and R += e[n] − e[n-WIN].
  - c and e are each delayed WIN samples.
  - P_re and P_im are 23-bit signed; R is 23-bit unsigned.
  - Sums cannot overflow for |x| ≤ 1; no saturation logic.
- Stage 4 computes the magnitude as max(|P_re|,|P_im|) + min(|P_re|,|P_im|)>>1, saturated to 23 bits unsigned, and registers it with R.
- A fill counter counts accepted samples up to LAG+WIN = 128 and then saturates.
  - `metric_vld` asserts only for samples accepted once the counter is at 128, i.e. from the 129th accepted sample onwards.
  - Outputs update before fill, but consumers must ignore them.
- `cyc_i` low on any edge:
  - accumulators, delay-line contents, fill counter, pipeline valid bits and all outputs clear to 0 on that edge;
  - the next frame requires 128 fresh samples before `metric_vld`.
- `ena` low: no acceptance; all state holds and in-flight pipeline entries still drain.

## Timing
- Reset values: `P_Metric_mag`=0, `R_Metric`=0, `metric_vld`=0. Accumulators, counters and delay lines are all 0.
- Latency is fixed: a sample accepted at edge k produces outputs and `metric_vld` at edge k+4.
- Throughput is one sample per clock. There is no back-pressure output.
- Outputs hold their last value between strobes.
- `rst` has priority over `cyc_i`, and `cyc_i` low has priority over acceptance.
- Flush mid-pipeline: samples in flight are discarded and no strobe is emitted for them.
- The delay-line read for index n−LAG returns the sample written LAG accepted samples earlier. The pointer wraps modulo depth.

## Configuration
- `SC_METRIC_ROUND_EN` defined:
  - the stage-2 shift by 15 uses round-half-up (add 2^14 before shifting);
  - the energy term saturates to 0x1FFFF.
- `SC_METRIC_ROUND_EN` undefined: plain truncation (floor).
- Latency and widths are identical in both builds.

## Structure
- The shared package holds:
  - constants `SC_LAG`, `SC_WIN`, `SC_FILL` (=128);
  - widths `SC_IN_W` (16), `SC_PROD_W` (18), `SC_ACC_W` (23);
  - a packed complex sample typedef.
- One sub-module, `sc_delay_line` (parameters WIDTH, DEPTH), is instantiated three times:
  - x delayed LAG;
  - c delayed WIN;
  - e delayed WIN.
- It is a circular buffer with an enable and a synchronous clear driven by rst or ~cyc_i.

## Test plan
- Constant x=0x4000+j0 (0.5), 200 samples:
  - first strobe is 4 cycles after the 129th accepted sample;
  - `P_Metric_mag`=0x080000 and `R_Metric`=0x080000 (16.0), steady thereafter.
- x=(0x4000,0x4000) constant: P=32.0 → `P_Metric_mag`=0x100000; `R_Metric`=0x100000.
- 64 samples of 0.5, then 64 of j0.5, repeated:
  - after fill, P_re→0 and P_im→16.0;
  - `P_Metric_mag` settles at 0x080000 and `R_Metric` stays 0x080000.
- `in_vld` low for 10 cycles mid-stream:
  - no strobes during the gap and outputs hold;
  - after resuming, the values match an uninterrupted run.
- `cyc_i` low for 1 cycle after 150 samples:
  - next edge all outputs are 0 and `metric_vld`=0;
  - strobes resume only after 128 new samples.
- All-zero input: metrics 0.
- x=0x0001 with `SC_METRIC_ROUND_EN` undefined: `R_Metric`=0. Defined: `R_Metric`=0 as well, since 1·1+2^14 < 2^15.
